// File: rtl/hook_line_renderer.sv
// hook_line_renderer: fishing line + hook sprite, positions divided by SCALE once per frame.
// Optional HOOK_BLINK_EN blinks the hook while a fish is caught.
module hook_line_renderer #(
    parameter int          POS_W        = 14,
    parameter int          CNT_W        = 10,
    parameter int          SCALE        = 10,
    parameter int          V_ACTIVE     = 480,
    parameter int          LINE_X       = 258,
    parameter int          LINE_TOP     = 72,
    parameter int          HOOK_W       = 7,
    parameter int          HOOK_H       = 10,
    parameter logic [11:0] LINE_COLOR   = 12'hfff,
    parameter logic [11:0] HOOK_COLOR   = 12'hfff,
    parameter int          BLINK_FRAMES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] h_position,
    input  logic [POS_W-1:0] v_position,
    input  logic             valid,
    input  logic [CNT_W-1:0] h_cnt,
    input  logic [CNT_W-1:0] v_cnt,
    input  logic             caught,
    output logic             pos_busy,
    output logic             background,
    output logic [11:0]      vga
);
    localparam int C_W = $clog2(POS_W);
    localparam logic [CNT_W-1:0] LX = CNT_W'(LINE_X);
    localparam logic [CNT_W-1:0] LT = CNT_W'(LINE_TOP);
    localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);
    localparam logic signed [CNT_W:0] HWS = (CNT_W+1)'(HOOK_W);
    localparam logic signed [CNT_W:0] HH1 = (CNT_W+1)'(HOOK_H - 1);
    localparam logic signed [CNT_W:0] ONE = (CNT_W+1)'(1);
    typedef enum logic {IDLE, DIV} state_t;
    state_t           state;
    logic             match, match_q, tick, pos_ok;
    logic [C_W-1:0]   cnt;
    logic [POS_W-1:0] qx, qy, rx, ry;
    logic [CNT_W-1:0] x_disp, y_disp;
    logic [2*POS_W-1:0] sx, sy;
    // one restoring step: quotient bits shift in at the bottom of the dividend register
    function automatic logic [2*POS_W-1:0] step(input logic [POS_W-1:0] r, input logic [POS_W-1:0] q);
        logic [POS_W:0] t;
        t = {r, q[POS_W-1]};
        step = (t >= (POS_W+1)'(SCALE)) ? {POS_W'(t - (POS_W+1)'(SCALE)), q[POS_W-2:0], 1'b1}
                                         : {t[POS_W-1:0], q[POS_W-2:0], 1'b0};
    endfunction
    assign match = (h_cnt == '0) && (v_cnt == VA);
    assign tick  = match && !match_q;
    assign sx    = step(rx, qx);
    assign sy    = step(ry, qy);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pos_busy <= 1'b0;
            pos_ok   <= 1'b0;
            match_q  <= 1'b0;
            x_disp   <= '0;
            y_disp   <= '0;
            cnt      <= '0;
            qx       <= '0;
            qy       <= '0;
            rx       <= '0;
            ry       <= '0;
        end else begin
            match_q <= match;
            if (state == IDLE) begin
                if (tick) begin
                    state    <= DIV;
                    pos_busy <= 1'b1;
                    qx       <= h_position;
                    qy       <= v_position;
                    rx       <= '0;
                    ry       <= '0;
                    cnt      <= '0;
                end
            end else begin
                {rx, qx} <= sx;
                {ry, qy} <= sy;
                cnt      <= cnt + 1'b1;
                if (cnt == C_W'(POS_W - 1)) begin
                    state    <= IDLE;
                    pos_busy <= 1'b0;
                    pos_ok   <= 1'b1;
                    x_disp   <= sx[CNT_W-1:0];
                    y_disp   <= sy[CNT_W-1:0];
                end
            end
        end
    end
    logic signed [CNT_W:0] dh, dv, lim;
    logic line_hit, hook_hit, show, valid_d, line_d, hook_d;
    assign dh  = $signed({1'b0, h_cnt}) - $signed({1'b0, x_disp});
    assign dv  = $signed({1'b0, v_cnt}) - $signed({1'b0, y_disp});
    assign lim = HH1 - ((dh + ONE) >>> 1);
    assign line_hit = (h_cnt == LX) && (v_cnt >= LT) && (v_cnt <= y_disp);
    assign hook_hit = !dh[CNT_W] && (dh < HWS) && (dv >= dh) && (dv <= lim);
`ifdef HOOK_BLINK_EN
    localparam int B_W = $clog2(BLINK_FRAMES + 1);
    logic [B_W-1:0] frames;
    logic           phase;
    assign show = !(caught && phase);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames <= '0;
            phase  <= 1'b0;
        end else if (!caught) begin
            frames <= '0;
            phase  <= 1'b0;
        end else if (tick) begin
            frames <= (frames == B_W'(BLINK_FRAMES - 1)) ? '0 : frames + 1'b1;
            phase  <= (frames == B_W'(BLINK_FRAMES - 1)) ? !phase : phase;
        end
    end
`else
    logic unused_caught;
    assign unused_caught = caught;
    assign show = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d    <= 1'b0;
            line_d     <= 1'b0;
            hook_d     <= 1'b0;
            vga        <= '0;
            background <= 1'b1;
        end else begin
            valid_d    <= valid;
            line_d     <= line_hit;
            hook_d     <= hook_hit && show;
            vga        <= (!valid_d || !pos_ok) ? 12'h000 : line_d ? LINE_COLOR : hook_d ? HOOK_COLOR : 12'h000;
            background <= !valid_d || !pos_ok || !(line_d || hook_d);
        end
    end
endmodule
